// File: rtl/lsu_pkg.sv
// lsu_pkg: shared widths, funct3 codes, FSM states and alignment helpers for the load/store unit
package lsu_pkg;
  localparam int XLEN = 32;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] o);
    return f3[1:0] == F3_H[1:0] ? o[0] : f3[1] ? |o : 1'b0;
  endfunction
  function automatic logic [1:0] force_align(input logic [2:0] f3, input logic [1:0] o);
    return f3[1:0] == F3_H[1:0] ? {o[1], 1'b0} : f3[1] ? 2'b00 : o;
  endfunction
endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: data-memory req/gnt/rvalid bus; master = LSU (req, we, addr, be, wdata), slave = memory (gnt, rvalid, rdata)
interface load_store_unit_if;
  import lsu_pkg::*;
  logic            req;
  logic            we;
  logic [XLEN-1:0] addr;
  logic [3:0]      be;
  logic [XLEN-1:0] wdata;
  logic            gnt;
  logic            rvalid;
  logic [XLEN-1:0] rdata;
  modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
  modport slave (input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/lsu_align.sv
// lsu_align: combinational byte enables, store lane replication and load extraction/extension (in: funct3, off, wdata, rdata; out: be, wdata_rep, rdata_ext)
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      off,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata,
  output logic [3:0]      be,
  output logic [XLEN-1:0] wdata_rep,
  output logic [XLEN-1:0] rdata_ext
);
  logic       is_b;
  logic       is_h;
  logic [7:0] lb;
  logic [15:0] lh;
  always_comb begin
    is_b = funct3[1:0] == F3_B[1:0];
    is_h = funct3[1:0] == F3_H[1:0];
    lb = rdata[{off, 3'b000} +: 8];
    lh = rdata[{off[1], 4'b0000} +: 16];
    be = is_b ? 4'b0001 << off : is_h ? 4'b0011 << {off[1], 1'b0} : 4'b1111;
    wdata_rep = is_b ? {4{wdata[7:0]}} : is_h ? {2{wdata[15:0]}} : wdata;
    rdata_ext = is_b ? {{24{lb[7] & ~funct3[2]}}, lb} : is_h ? {{16{lh[15] & ~funct3[2]}}, lh} : rdata;
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: memory stage (ex_* in, lsu_stall/wb_*/lsu_exc* out, mem bus master); LSU_MISALIGN_TRAP_EN traps misaligned accesses
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int RD_W = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ex_valid,
  input  logic                   ex_memread,
  input  logic                   ex_memwrite,
  input  logic [2:0]             ex_funct3,
  input  logic [XLEN-1:0]        ex_addr,
  input  logic [XLEN-1:0]        ex_wdata,
  input  logic [RD_W-1:0]        ex_rd,
  output logic                   lsu_stall,
  load_store_unit_if.master      mem,
  output logic                   wb_valid,
  output logic                   wb_we,
  output logic [RD_W-1:0]        wb_rd,
  output logic [XLEN-1:0]        wb_data,
  output logic                   lsu_exc,
  output logic [XLEN-1:0]        lsu_exc_addr
);
  state_t          state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d, data_q, data_d;
  logic [2:0]      f3_q, f3_d;
  logic [RD_W-1:0] rd_q, rd_d;
  logic            ld_q, ld_d, exc_q, exc_d;
  logic            acc, mis, req, done;
  logic [XLEN-1:0] addr_n;
  logic [3:0]      be;
  logic [XLEN-1:0] wrep, rext;
  lsu_align u_align (
    .funct3    (f3_q),
    .off       (addr_q[1:0]),
    .wdata     (wdata_q),
    .rdata     (mem.rdata),
    .be        (be),
    .wdata_rep (wrep),
    .rdata_ext (rext)
  );
  always_comb begin
    acc = ex_valid & (ex_memread | ex_memwrite);
`ifdef LSU_MISALIGN_TRAP_EN
    mis = misaligned(ex_funct3, ex_addr[1:0]);
    addr_n = ex_addr;
`else
    mis = 1'b0;
    addr_n = {ex_addr[XLEN-1:2], force_align(ex_funct3, ex_addr[1:0])};
`endif
    state_d = state_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    data_d = data_q;
    f3_d = f3_q;
    rd_d = rd_q;
    ld_d = ld_q;
    exc_d = exc_q;
    case (state_q)
      IDLE: if (acc) begin
        addr_d = addr_n;
        wdata_d = ex_wdata;
        f3_d = ex_funct3;
        rd_d = ex_rd;
        ld_d = ex_memread;
        exc_d = mis;
        state_d = mis ? DONE : REQ;
      end
      REQ: if (mem.gnt) state_d = ld_q ? WAIT : DONE;
      WAIT: if (mem.rvalid) begin
        data_d = rext;
        state_d = DONE;
      end
      default: begin
        exc_d = 1'b0;
        state_d = IDLE;
      end
    endcase
    req = state_q == REQ;
    done = state_q == DONE;
    lsu_stall = acc & ~done;
    mem.req = req;
    mem.we = req & ~ld_q;
    mem.addr = req ? {addr_q[XLEN-1:2], 2'b00} : '0;
    mem.be = req ? be : 4'b0000;
    mem.wdata = req ? wrep : '0;
    wb_valid = done;
    wb_we = done & ld_q & ~exc_q;
    wb_rd = done ? rd_q : '0;
    wb_data = done & ld_q & ~exc_q ? data_q : '0;
    lsu_exc = done & exc_q;
    lsu_exc_addr = done & exc_q ? addr_q : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      data_q <= '0;
      f3_q <= '0;
      rd_q <= '0;
      ld_q <= 1'b0;
      exc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      data_q <= data_d;
      f3_q <= f3_d;
      rd_q <= rd_d;
      ld_q <= ld_d;
      exc_q <= exc_d;
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench with a delay-programmable memory responder for load_store_unit
module tb_load_store_unit;
  import lsu_pkg::*;
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          gdly;
    int          rdly;
  } req_t;
  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        exc;
    logic [31:0] exc_addr;
  } wb_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0;
  logic        ex_memread = 1'b0;
  logic        ex_memwrite = 1'b0;
  logic [2:0]  ex_funct3 = 3'b000;
  logic [31:0] ex_addr = '0;
  logic [31:0] ex_wdata = '0;
  logic [4:0]  ex_rd = '0;
  logic        lsu_stall, wb_valid, wb_we, lsu_exc;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, lsu_exc_addr;
  req_t        req_q[$];
  wb_t         wb_q[$];
  int          checks = 0;
  int          errors = 0;
  load_store_unit_if mem_if ();
  load_store_unit #(.RD_W(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .ex_valid     (ex_valid),
    .ex_memread   (ex_memread),
    .ex_memwrite  (ex_memwrite),
    .ex_funct3    (ex_funct3),
    .ex_addr      (ex_addr),
    .ex_wdata     (ex_wdata),
    .ex_rd        (ex_rd),
    .lsu_stall    (lsu_stall),
    .mem          (mem_if.master),
    .wb_valid     (wb_valid),
    .wb_we        (wb_we),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .lsu_exc      (lsu_exc),
    .lsu_exc_addr (lsu_exc_addr)
  );
  always #5 clk = ~clk;
  function automatic req_t mk_req(input logic we, input logic [31:0] a, input logic [3:0] be,
                                  input logic [31:0] wd, rdw, input int g, r);
    req_t x;
    x.we = we; x.addr = a; x.be = be; x.wdata = wd; x.rdata = rdw; x.gdly = g; x.rdly = r;
    return x;
  endfunction
  function automatic wb_t mk_wb(input logic we, input logic [4:0] rd, input logic [31:0] d,
                                input logic exc, input logic [31:0] ea);
    wb_t x;
    x.we = we; x.rd = rd; x.data = d; x.exc = exc; x.exc_addr = ea;
    return x;
  endfunction
  initial begin : responder
    int wcnt, rcnt, rdly;
    bit rpend;
    logic [31:0] rword;
    wcnt = 0; rcnt = 0; rdly = 0; rpend = 0; rword = '0;
    mem_if.gnt = 1'b0; mem_if.rvalid = 1'b0; mem_if.rdata = '0;
    forever begin
      @(negedge clk);
      mem_if.gnt = 1'b0;
      mem_if.rvalid = 1'b0;
      mem_if.rdata = $urandom;
      if (mem_if.req === 1'b1 && !rst) begin
        checks++;
        if (req_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_req addr=%h be=%b we=%b required no request", mem_if.addr, mem_if.be, mem_if.we);
        end else begin
          if (mem_if.we !== req_q[0].we || mem_if.addr !== req_q[0].addr || mem_if.be !== req_q[0].be ||
              (req_q[0].we && mem_if.wdata !== req_q[0].wdata)) begin
            errors++;
            $display("FAIL req_fields got we=%b addr=%h be=%b wdata=%h required we=%b addr=%h be=%b wdata=%h",
                     mem_if.we, mem_if.addr, mem_if.be, mem_if.wdata,
                     req_q[0].we, req_q[0].addr, req_q[0].be, req_q[0].wdata);
          end
          if (wcnt == req_q[0].gdly) begin
            mem_if.gnt = 1'b1;
            wcnt = 0;
            if (!req_q[0].we) begin
              rpend = 1; rcnt = 0; rdly = req_q[0].rdly; rword = req_q[0].rdata;
            end
            void'(req_q.pop_front());
          end else wcnt++;
        end
      end else if (rpend) begin
        rcnt++;
        if (rcnt == rdly) begin
          mem_if.rvalid = 1'b1;
          mem_if.rdata = rword;
          rpend = 0;
        end
      end
    end
  end
  initial begin : monitor
    wb_t e;
    forever begin
      @(negedge clk);
      if (wb_valid === 1'b1) begin
        checks++;
        if (wb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_wb rd=%0d data=%h required no writeback", wb_rd, wb_data);
        end else begin
          e = wb_q.pop_front();
          if (wb_we !== e.we || wb_rd !== e.rd || (e.we && wb_data !== e.data) ||
              lsu_exc !== e.exc || lsu_exc_addr !== e.exc_addr) begin
            errors++;
            $display("FAIL wb_fields got we=%b rd=%0d data=%h exc=%b exc_addr=%h required we=%b rd=%0d data=%h exc=%b exc_addr=%h",
                     wb_we, wb_rd, wb_data, lsu_exc, lsu_exc_addr, e.we, e.rd, e.data, e.exc, e.exc_addr);
          end
        end
      end
    end
  end
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end
  task automatic run_op(input bit ld, input bit both, input logic [2:0] f3, input logic [31:0] a, wd,
                        input logic [4:0] rd, output int cyc);
    @(negedge clk);
    ex_valid = 1'b1;
    ex_memread = ld;
    ex_memwrite = !ld | both;
    ex_funct3 = f3;
    ex_addr = a;
    ex_wdata = wd;
    ex_rd = rd;
    cyc = 0;
    #1;
    while (lsu_stall === 1'b1 && cyc < 50) begin
      @(negedge clk);
      #1;
      cyc++;
    end
  endtask
  task automatic ex_clear;
    @(negedge clk);
    ex_valid = 1'b0;
    ex_memread = 1'b0;
    ex_memwrite = 1'b0;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({mem_if.req, mem_if.we, mem_if.be, mem_if.addr, mem_if.wdata} !== '0) begin
      errors++;
      $display("FAIL reset_mem got req=%b we=%b be=%b addr=%h wdata=%h required all zero",
               mem_if.req, mem_if.we, mem_if.be, mem_if.addr, mem_if.wdata);
    end
    checks++;
    if ({wb_valid, wb_we, wb_rd, wb_data} !== '0) begin
      errors++;
      $display("FAIL reset_wb got valid=%b we=%b rd=%0d data=%h required all zero", wb_valid, wb_we, wb_rd, wb_data);
    end
    checks++;
    if ({lsu_exc, lsu_exc_addr, lsu_stall} !== '0) begin
      errors++;
      $display("FAIL reset_exc got exc=%b exc_addr=%h stall=%b required all zero", lsu_exc, lsu_exc_addr, lsu_stall);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic test_store_word;
    int cyc;
    req_q.push_back(mk_req(1, 32'h1000, 4'b1111, 32'hDEADBEEF, 0, 0, 0));
    wb_q.push_back(mk_wb(0, 5'd3, 0, 0, 0));
    run_op(0, 0, F3_W, 32'h1000, 32'hDEADBEEF, 5'd3, cyc);
    checks++;
    if (cyc !== 2 || wb_valid !== 1'b1 || wb_we !== 1'b0) begin
      errors++;
      $display("FAIL sw_timing got stall_cycles=%0d wb_valid=%b wb_we=%b required 2 1 0", cyc, wb_valid, wb_we);
    end
    ex_clear();
  endtask
  task automatic test_store_sub;
    int cyc;
    req_q.push_back(mk_req(1, 32'h1000, 4'b1000, 32'hA5A5A5A5, 0, 0, 0));
    wb_q.push_back(mk_wb(0, 5'd4, 0, 0, 0));
    run_op(0, 0, F3_B, 32'h1003, 32'h000000A5, 5'd4, cyc);
    checks++;
    if (cyc !== 2) begin
      errors++;
      $display("FAIL sb_timing got %0d required 2", cyc);
    end
    ex_clear();
    req_q.push_back(mk_req(1, 32'h1000, 4'b1100, 32'h12341234, 0, 1, 0));
    wb_q.push_back(mk_wb(0, 5'd5, 0, 0, 0));
    run_op(0, 0, F3_H, 32'h1002, 32'hFFFF1234, 5'd5, cyc);
    checks++;
    if (cyc !== 3) begin
      errors++;
      $display("FAIL sh_timing got %0d required 3", cyc);
    end
    ex_clear();
  endtask
  task automatic test_load_byte;
    int cyc;
    req_q.push_back(mk_req(0, 32'h2000, 4'b0010, 0, 32'h00008000, 0, 3));
    wb_q.push_back(mk_wb(1, 5'd7, 32'hFFFFFF80, 0, 0));
    run_op(1, 0, F3_B, 32'h2001, 0, 5'd7, cyc);
    checks++;
    if (cyc !== 5 || wb_rd !== 5'd7) begin
      errors++;
      $display("FAIL lb_timing got cycles=%0d rd=%0d required 5 7", cyc, wb_rd);
    end
    ex_clear();
    req_q.push_back(mk_req(0, 32'h2000, 4'b0010, 0, 32'h00008000, 0, 1));
    wb_q.push_back(mk_wb(1, 5'd9, 32'h00000080, 0, 0));
    run_op(1, 1, F3_BU, 32'h2001, 0, 5'd9, cyc);
    checks++;
    if (cyc !== 3 || wb_data !== 32'h00000080) begin
      errors++;
      $display("FAIL lbu_timing got cycles=%0d data=%h required 3 00000080", cyc, wb_data);
    end
    ex_clear();
  endtask
  task automatic test_load_half_stall;
    int cyc;
    req_q.push_back(mk_req(0, 32'h2000, 4'b1100, 0, 32'h80010000, 4, 1));
    wb_q.push_back(mk_wb(1, 5'd10, 32'hFFFF8001, 0, 0));
    run_op(1, 0, F3_H, 32'h2002, 0, 5'd10, cyc);
    checks++;
    if (cyc !== 7) begin
      errors++;
      $display("FAIL lh_gnt_stall got %0d required 7", cyc);
    end
    ex_clear();
    req_q.push_back(mk_req(0, 32'h2000, 4'b1100, 0, 32'h80010000, 0, 2));
    wb_q.push_back(mk_wb(1, 5'd11, 32'h00008001, 0, 0));
    run_op(1, 0, F3_HU, 32'h2002, 0, 5'd11, cyc);
    checks++;
    if (cyc !== 4) begin
      errors++;
      $display("FAIL lhu_timing got %0d required 4", cyc);
    end
    ex_clear();
  endtask
  task automatic test_reset_in_wait;
    req_q.push_back(mk_req(0, 32'h4000, 4'b1111, 0, 32'h12345678, 0, 4));
    @(negedge clk);
    ex_valid = 1'b1; ex_memread = 1'b1; ex_memwrite = 1'b0;
    ex_funct3 = F3_W; ex_addr = 32'h4000; ex_rd = 5'd12;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (lsu_stall !== 1'b1 || mem_if.req !== 1'b0 || wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL wait_state got stall=%b req=%b wb_valid=%b required 1 0 0", lsu_stall, mem_if.req, wb_valid);
    end
    rst = 1'b1;
    ex_valid = 1'b0; ex_memread = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      #1;
      checks++;
      if (wb_valid !== 1'b0 || mem_if.req !== 1'b0 || lsu_stall !== 1'b0) begin
        errors++;
        $display("FAIL reset_abandon got wb_valid=%b req=%b stall=%b required 0 0 0", wb_valid, mem_if.req, lsu_stall);
      end
    end
  endtask
  task automatic test_misalign;
    int cyc;
`ifdef LSU_MISALIGN_TRAP_EN
    wb_q.push_back(mk_wb(0, 5'd13, 0, 1, 32'h3002));
    run_op(1, 0, F3_W, 32'h3002, 0, 5'd13, cyc);
    checks++;
    if (cyc !== 1 || lsu_exc !== 1'b1 || lsu_exc_addr !== 32'h3002 || wb_we !== 1'b0) begin
      errors++;
      $display("FAIL lw_trap got cycles=%0d exc=%b exc_addr=%h we=%b required 1 1 00003002 0", cyc, lsu_exc, lsu_exc_addr, wb_we);
    end
    ex_clear();
    wb_q.push_back(mk_wb(0, 5'd14, 0, 1, 32'h3001));
    run_op(0, 0, F3_H, 32'h3001, 32'h0000BEEF, 5'd14, cyc);
    checks++;
    if (cyc !== 1 || lsu_exc !== 1'b1) begin
      errors++;
      $display("FAIL sh_trap got cycles=%0d exc=%b required 1 1", cyc, lsu_exc);
    end
    ex_clear();
`else
    req_q.push_back(mk_req(0, 32'h3000, 4'b1111, 0, 32'h11223344, 0, 1));
    wb_q.push_back(mk_wb(1, 5'd13, 32'h11223344, 0, 0));
    run_op(1, 0, F3_W, 32'h3002, 0, 5'd13, cyc);
    checks++;
    if (cyc !== 3 || lsu_exc !== 1'b0 || wb_data !== 32'h11223344) begin
      errors++;
      $display("FAIL lw_force_align got cycles=%0d exc=%b data=%h required 3 0 11223344", cyc, lsu_exc, wb_data);
    end
    ex_clear();
    req_q.push_back(mk_req(1, 32'h3000, 4'b0011, 32'hBEEFBEEF, 0, 0, 0));
    wb_q.push_back(mk_wb(0, 5'd14, 0, 0, 0));
    run_op(0, 0, F3_H, 32'h3001, 32'h0000BEEF, 5'd14, cyc);
    checks++;
    if (cyc !== 2 || lsu_exc !== 1'b0) begin
      errors++;
      $display("FAIL sh_force_align got cycles=%0d exc=%b required 2 0", cyc, lsu_exc);
    end
    ex_clear();
`endif
  endtask
  task automatic test_back_to_back;
    int c1, c2;
    req_q.push_back(mk_req(1, 32'h5000, 4'b1111, 32'hCAFEF00D, 0, 0, 0));
    wb_q.push_back(mk_wb(0, 5'd15, 0, 0, 0));
    req_q.push_back(mk_req(0, 32'h5004, 4'b1111, 0, 32'h87654321, 0, 1));
    wb_q.push_back(mk_wb(1, 5'd16, 32'h87654321, 0, 0));
    run_op(0, 0, F3_W, 32'h5000, 32'hCAFEF00D, 5'd15, c1);
    run_op(1, 0, F3_W, 32'h5004, 0, 5'd16, c2);
    checks++;
    if (c1 !== 2 || c2 !== 3) begin
      errors++;
      $display("FAIL back_to_back got cycles=%0d,%0d required 2,3", c1, c2);
    end
    ex_clear();
  endtask
  initial begin
    test_reset();
    test_store_word();
    test_store_sub();
    test_load_byte();
    test_load_half_stall();
    test_reset_in_wait();
    test_misalign();
    test_back_to_back();
    repeat (4) @(negedge clk);
    checks++;
    if (req_q.size() != 0 || wb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got req=%0d wb=%0d pending required 0 0", req_q.size(), wb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory stage that sits directly downstream of the execute ALU. It consumes the ALU's effective address (BTA output, rs1+imm for loads/stores), memread/memwrite, funct3 and rs2 store data.
- It runs a request/grant/response handshake with the data memory, generates byte enables and lane-replicated store data, and returns sign- or zero-extended load data to writeback.
- It stalls the pipeline while an access is outstanding.

Parameters:
- XLEN, 32, data/address width (only 32 is supported)
- RD_W, 5, width of the destination-register tag carried through to writeback

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- ex_valid  in  1  an instruction is present in EX this cycle
- ex_memread  in  1  the instruction is a load
- ex_memwrite  in  1  the instruction is a store
- ex_funct3  in  3  access size/sign (RV32I encoding)
- ex_addr  in  XLEN  effective address from the ALU BTA adder
- ex_wdata  in  XLEN  rs2 store data
- ex_rd  in  RD_W  destination register of the load
- lsu_stall  out  1  hold EX and upstream stages
- mem_req  out  1  memory request valid
- mem_we  out  1  1 = write
- mem_addr  out  XLEN  word-aligned address ({addr[31:2],2'b00})
- mem_be  out  4  byte enables
- mem_wdata  out  XLEN  lane-replicated store data
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  XLEN  read word
- wb_valid  out  1  access complete (one-cycle pulse)
- wb_we  out  1  write wb_data to wb_rd (loads only)
- wb_rd  out  RD_W  destination tag
- wb_data  out  XLEN  extended load data
- lsu_exc  out  1  misaligned-access exception (feature-dependent)
- lsu_exc_addr  out  XLEN  faulting address

Behaviour:
- Reset: state=IDLE. All outputs are 0: mem_req, mem_we, mem_be, mem_addr, mem_wdata, wb_*, lsu_exc, lsu_exc_addr.
- FSM states: IDLE, REQ, WAIT, DONE.
- Access condition: acc = ex_valid & (ex_memread | ex_memwrite). If both memread and memwrite are set, the access is a load.
- IDLE:
  - If acc: latch addr, funct3, wdata, rd and type, then go to REQ.
  - lsu_stall is combinational: acc & state in {IDLE, REQ, WAIT}.
- REQ:
  - mem_req=1 with the latched request; all request fields stay stable until mem_gnt.
  - On gnt: a store goes to DONE, a load goes to WAIT.
- WAIT:
  - mem_rvalid is sampled only in WAIT, never in the gnt cycle.
  - On rvalid: latch the extended data, then go to DONE.
- DONE:
  - wb_valid=1 for exactly one cycle; lsu_stall=0 so the pipeline advances.
  - No new access is accepted in DONE. Next state is IDLE.
- Minimum latency (acceptance cycle T):
  - Store: gnt at T+1, wb_valid at T+2.
  - Load: gnt at T+1, rvalid at T+2, wb_valid at T+3.
- Byte enables, with o = addr[1:0]:
  - SB: 0001<<o
  - SH: 0011<<{o[1],0}
  - SW / funct3 011,110,111: 1111, treated as a word access.
- Store data: SB replicates the byte into all four lanes; SH replicates the halfword into both halves; SW passes through.
- Load extraction from mem_rdata, lane selected by o:
  - LB/LH: sign-extend
  - LBU/LHU: zero-extend
  - LW: raw word
- wb_we=1 only for loads, only in DONE, and only when lsu_exc=0. wb_rd = latched rd.
- An rvalid arriving in IDLE, REQ or DONE is ignored.
- Reset in any state returns to IDLE next cycle; the outstanding request is abandoned with no wb pulse.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- Misaligned means halfword with addr[0]=1, or word with addr[1:0]!=0.
- With the macro defined:
  - A misaligned access goes IDLE->DONE with no memory request.
  - DONE asserts wb_valid=1, lsu_exc=1, lsu_exc_addr=addr, wb_we=0.
- Without the macro:
  - Low address bits are forced aligned (half: [0]=0; word: [1:0]=0).
  - lsu_exc and lsu_exc_addr are tied to 0.

Decomposition:
- Package lsu_pkg holds:
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101
  - FSM state typedef (IDLE, REQ, WAIT, DONE)
  - XLEN
- Sub-module lsu_align: purely combinational. Computes be, wdata replication and load extraction/extension from funct3, addr[1:0] and rdata, so the same logic is shared by the FSM's request and response paths.

Test Plan:
- SW addr 0x1000, data 0xDEADBEEF, gnt at T+1 -> mem_req at T+1 with be=1111, addr=0x1000; wb_valid at T+2 with wb_we=0; stall high at T and T+1, low at T+2.
- SB addr 0x1003, data 0x000000A5 -> be=1000, wdata=0xA5A5A5A5, mem_addr=0x1000.
- LB addr 0x2001, rdata=0x00008000 with rvalid 3 cycles after gnt -> wb_data=0xFFFFFF80, wb_rd matches the latched tag. Repeat as LBU -> 0x00000080.
- LH addr 0x2002, rdata=0x80010000; gnt withheld for 4 cycles -> req, addr and be held stable throughout; wb_data=0xFFFF8001.
- Reset asserted in WAIT, then rvalid arrives -> IDLE with no wb_valid; the stray rvalid is ignored.
- LW addr 0x3002: with LSU_MISALIGN_TRAP_EN -> no mem_req, lsu_exc=1, lsu_exc_addr=0x3002. Without it -> mem_addr=0x3000, normal load.
